// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the MEM-stage bus interface: state encoding,
// read/write and active-low strobe levels, and the default scratch-pad tag.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        ACCESS = 2'd2,
        STALL  = 2'd3
    } mem_bus_state_t;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    localparam int unsigned    CPU_SPM_TAG_W = 3;
    localparam logic [2:0]     CPU_SPM_TAG   = 3'b011;

endpackage

// File: rtl/mem_bus_if.sv
// MEM-stage bus interface: zero-wait scratch-pad path plus an arbitrated shared bus.
// Optional bus watchdog enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_if
    import cpu_pkg::*;
#(
    parameter int unsigned                ADDR_W      = 30,
    parameter int unsigned                DATA_W      = 32,
    parameter int unsigned                SPM_TAG_W   = CPU_SPM_TAG_W,
    parameter logic [SPM_TAG_W-1:0]       SPM_TAG     = CPU_SPM_TAG,
    parameter int unsigned                TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    output logic              busy,
    input  logic [ADDR_W-1:0] addr,
    input  logic              as_,
    input  logic              rw,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic              bus_req_,
    input  logic              bus_grant_,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic              bus_rdy_,
    input  logic [DATA_W-1:0] bus_rd_data,
    output logic              bus_err
);

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("mem_bus_if: TIMEOUT_CYC must be in 1..255");
    end

    mem_bus_state_t    state;
    mem_bus_state_t    state_next;
    logic [DATA_W-1:0] rd_buf;
    logic              spm_hit;
    logic              tmo_hit;

    assign spm_addr    = addr;
    assign spm_wr_data = wr_data;
    assign spm_hit     = (state == IDLE) && (as_ == ENABLE_) && !flush &&
                         (addr[ADDR_W-1 -: SPM_TAG_W] == SPM_TAG);
    assign spm_as_     = spm_hit ? ENABLE_ : DISABLE_;
    assign spm_rw      = spm_hit ? rw : READ;

`ifdef MEM_BUS_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Counts slave wait cycles; held at zero outside ACCESS so every access starts fresh.
    always_ff @(posedge clk) begin
        if (reset || state != ACCESS) begin
            tmo_cnt <= '0;
        end else if (bus_rdy_ == DISABLE_) begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end

    assign tmo_hit = (state == ACCESS) && (bus_rdy_ == DISABLE_) &&
                     (tmo_cnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign bus_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        rd_data    = '0;
        unique case (state)
            IDLE: begin
                if (spm_hit) begin
                    rd_data = spm_rd_data;
                end else if (as_ == ENABLE_ && !flush) begin
                    busy       = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                busy = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else if (bus_grant_ == ENABLE_) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // A ready in the timeout cycle takes priority over the watchdog.
                if (bus_rdy_ == ENABLE_) begin
                    rd_data    = bus_rd_data;
                    state_next = (stall && !flush) ? STALL : IDLE;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            STALL: begin
                rd_data = rd_buf;
                if (!stall || flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_buf      <= '0;
            bus_req_    <= DISABLE_;
            bus_as_     <= DISABLE_;
            bus_rw      <= READ;
            bus_addr    <= '0;
            bus_wr_data <= '0;
        end else begin
            state   <= state_next;
            bus_as_ <= DISABLE_;
            unique case (state)
                IDLE: begin
                    if (!spm_hit && as_ == ENABLE_ && !flush) begin
                        bus_req_    <= ENABLE_;
                        bus_addr    <= addr;
                        bus_rw      <= rw;
                        bus_wr_data <= wr_data;
                    end
                end
                REQ: begin
                    if (flush) begin
                        bus_req_ <= DISABLE_;
                    end else if (bus_grant_ == ENABLE_) begin
                        bus_as_ <= ENABLE_;
                    end
                end
                ACCESS: begin
                    if (bus_rdy_ == ENABLE_) begin
                        rd_buf   <= bus_rd_data;
                        bus_req_ <= DISABLE_;
                    end else if (tmo_hit) begin
                        bus_req_ <= DISABLE_;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
